// File: rtl/fpu_pkg.sv
// Shared rounding definitions: mode encodings, precision LSB positions and
// helpers that slice the sticky-reduced significand for either precision.
package fpu_pkg;

  typedef enum logic [1:0] {
    RM_RNE = 2'b00,
    RM_RZ  = 2'b01,
    RM_RPI = 2'b10,
    RM_RNI = 2'b11
  } rm_e;

  // Index of the precision LSB inside the 53-bit 1.52 significand.
  localparam int unsigned LSB_DBL = 0;
  localparam int unsigned LSB_SGL = 29;

  typedef struct packed {
    logic lsb;
    logic rnd;
    logic stk;
  } grs_t;

  // f1 carries two extra low bits (round, sticky) below the 53-bit significand.
  function automatic logic [52:0] trunc_sig(input logic [54:0] f1, input logic db);
    logic [52:0] sig;
    sig = db ? f1[54:2] : {f1[54:LSB_SGL+2], {LSB_SGL{1'b0}}};
    return sig;
  endfunction

  function automatic grs_t pick_grs(input logic [54:0] f1, input logic db);
    grs_t g;
    g.lsb = db ? f1[LSB_DBL+2] : f1[LSB_SGL+2];
    g.rnd = db ? f1[LSB_DBL+1] : f1[LSB_SGL+1];
    g.stk = db ? f1[LSB_DBL]   : f1[LSB_SGL];
    return g;
  endfunction

endpackage

// File: rtl/rnd_dec.sv
// Round-increment decision for the four IEEE rounding modes.
module rnd_dec
  import fpu_pkg::*;
(
  input  logic [1:0] rm,
  input  logic       sign,
  input  logic       lsb,
  input  logic       rnd,
  input  logic       stk,
  output logic       inc
);

  // Select the increment rule for the active rounding mode.
  always_comb begin
    inc = 1'b0;
    case (rm)
      RM_RNE:  inc = rnd & (lsb | stk);
      RM_RZ:   inc = 1'b0;
      RM_RPI:  inc = ~sign & (rnd | stk);
      RM_RNI:  inc = sign & (rnd | stk);
      default: inc = 1'b0;
    endcase
  end

endmodule

// File: rtl/sig_round_pipe.sv
// Two-stage significand rounding pipeline with valid/ready flow control:
// stage 1 truncates and decides the increment, stage 2 adds and post-normalises.
module sig_round_pipe
  import fpu_pkg::*;
#(
  parameter int EW = 13
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [54:0]   f1,
  input  logic          db,
  input  logic [EW-1:0] e_in,
  input  logic          s,
  input  logic [1:0]    rm,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [52:0]   f2,
  output logic [EW-1:0] e_out,
  output logic          s_out,
  output logic          inexact,
  output logic          sig_ovf
);

  grs_t          grs_s;
  logic [52:0]   trunc_s;
  logic          inc_s;

  logic          s1_valid_r;
  logic [52:0]   s1_sig_r;
  logic          s1_inc_r;
  logic          s1_inex_r;
  logic [EW-1:0] s1_exp_r;
  logic          s1_sign_r;
  logic          s1_db_r;

  logic          s1_adv_s;
  logic [53:0]   inc_vec_s;
  logic [53:0]   sum_s;
  logic          carry_s;
  logic [52:0]   f2_nxt_s;
  logic [EW-1:0] e_nxt_s;

  assign trunc_s = trunc_sig(f1, db);
  assign grs_s   = pick_grs(f1, db);

  rnd_dec u_rnd_dec (
    .rm   (rm),
    .sign (s),
    .lsb  (grs_s.lsb),
    .rnd  (grs_s.rnd),
    .stk  (grs_s.stk),
    .inc  (inc_s)
  );

  // Stage 1 may move on whenever stage 2 is empty or being drained this cycle.
  assign s1_adv_s = ~out_valid | out_ready;
  assign in_ready = ~s1_valid_r | s1_adv_s;

  // Stage 1 register: truncated significand plus rounding decision.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_r <= 1'b0;
      s1_sig_r   <= 53'd0;
      s1_inc_r   <= 1'b0;
      s1_inex_r  <= 1'b0;
      s1_exp_r   <= {EW{1'b0}};
      s1_sign_r  <= 1'b0;
      s1_db_r    <= 1'b0;
    end else if (in_ready) begin
      s1_valid_r <= in_valid;
      if (in_valid) begin
        s1_sig_r  <= trunc_s;
        s1_inc_r  <= inc_s;
        s1_inex_r <= grs_s.rnd | grs_s.stk;
        s1_exp_r  <= e_in;
        s1_sign_r <= s;
        s1_db_r   <= db;
      end
    end
  end

  // A carry out of bit 52 leaves an all-zero fraction, so the result is 1.0 x 2^(e+1).
  assign inc_vec_s = s1_db_r ? (54'd1 << LSB_DBL) : (54'd1 << LSB_SGL);
  assign sum_s     = {1'b0, s1_sig_r} + (s1_inc_r ? inc_vec_s : 54'd0);
  assign carry_s   = sum_s[53];
  assign f2_nxt_s  = carry_s ? {1'b1, 52'd0} : sum_s[52:0];
  assign e_nxt_s   = carry_s ? (s1_exp_r + EW'(1)) : s1_exp_r;

  // Stage 2 register drives the outputs and holds them while stalled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      f2        <= 53'd0;
      e_out     <= {EW{1'b0}};
      s_out     <= 1'b0;
      inexact   <= 1'b0;
      sig_ovf   <= 1'b0;
    end else if (s1_adv_s) begin
      out_valid <= s1_valid_r;
      if (s1_valid_r) begin
        f2      <= f2_nxt_s;
        e_out   <= e_nxt_s;
        s_out   <= s1_sign_r;
        inexact <= s1_inex_r;
        sig_ovf <= carry_s;
      end
    end
  end

endmodule

// File: tb/tb_sig_round_pipe.sv
// Directed self-checking bench for sig_round_pipe: rounding vectors, flow
// control under stalls, and mid-flight reset.
module tb_sig_round_pipe;

  localparam int EW = 13;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [54:0]   f1 = 55'd0;
  logic          db = 1'b0;
  logic [EW-1:0] e_in = {EW{1'b0}};
  logic          s = 1'b0;
  logic [1:0]    rm = 2'b00;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [52:0]   f2;
  logic [EW-1:0] e_out;
  logic          s_out;
  logic          inexact;
  logic          sig_ovf;

  int n_cmp = 0;
  int n_err = 0;

  sig_round_pipe #(.EW(EW)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .f1        (f1),
    .db        (db),
    .e_in      (e_in),
    .s         (s),
    .rm        (rm),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .f2        (f2),
    .e_out     (e_out),
    .s_out     (s_out),
    .inexact   (inexact),
    .sig_ovf   (sig_ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One isolated word: check handshake, exact two-cycle latency and all result fields.
  task automatic run_one(input string tag, input logic d, input logic sg, input logic [1:0] m,
                         input logic [54:0] f, input logic [EW-1:0] e,
                         input logic [52:0] xf2, input logic [EW-1:0] xe,
                         input logic xinex, input logic xovf);
    @(negedge clk);
    db = d; s = sg; rm = m; f1 = f; e_in = e; in_valid = 1'b1; out_ready = 1'b1;
    #1 chk({tag, "_rdy"}, 64'(in_ready), 64'd1);
    @(negedge clk);
    in_valid = 1'b0;
    #1 chk({tag, "_lat"}, 64'(out_valid), 64'd0);
    @(negedge clk);
    #1;
    chk({tag, "_vld"}, 64'(out_valid), 64'd1);
    chk({tag, "_f2"}, 64'(f2), 64'(xf2));
    chk({tag, "_exp"}, 64'(e_out), 64'(xe));
    chk({tag, "_sgn"}, 64'(s_out), 64'(sg));
    chk({tag, "_inx"}, 64'(inexact), 64'(xinex));
    chk({tag, "_ovf"}, 64'(sig_ovf), 64'(xovf));
  endtask

  // Eight back-to-back words; mode 0 always ready, mode 1 out_ready pattern 1,0,0 repeating.
  task automatic stream(input int mode);
    int q[$];
    int sent = 0;
    int got = 0;
    int cyc = 0;
    logic acc;
    logic dlv;
    while (got < 8 && cyc < 200) begin
      @(negedge clk);
      out_ready = (mode == 0) ? 1'b1 : ((cyc % 3) == 0);
      if (sent < 8) begin
        in_valid = 1'b1; db = 1'b1; rm = 2'b01; s = 1'b0;
        f1 = {1'b1, 52'(4096 + sent), 2'b00};
        e_in = EW'(100 + sent);
      end else begin
        in_valid = 1'b0;
      end
      #1;
      chk("strm_rdy", 64'(in_ready), 64'(!(q.size() == 2 && !out_ready)));
      if (out_valid) begin
        chk("strm_occ", 64'(q.size() != 0), 64'd1);
        if (q.size() != 0) begin
          chk("strm_f2", 64'(f2), 64'({1'b1, 52'(4096 + q[0])}));
          chk("strm_exp", 64'(e_out), 64'(EW'(100 + q[0])));
        end
      end
      acc = in_valid & in_ready;
      dlv = out_valid & out_ready;
      @(posedge clk);
      if (acc) begin
        q.push_back(sent);
        sent++;
      end
      if (dlv && q.size() != 0) begin
        void'(q.pop_front());
        got++;
      end
      cyc++;
    end
    @(negedge clk);
    in_valid = 1'b0;
    chk("strm_count", 64'(got), 64'd8);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    chk("rst_vld", 64'(out_valid), 64'd0);
    chk("rst_f2", 64'(f2), 64'd0);
    chk("rst_exp", 64'(e_out), 64'd0);
    chk("rst_flags", 64'({s_out, inexact, sig_ovf}), 64'd0);
    rst = 1'b0;
    #1 chk("rst_rdy", 64'(in_ready), 64'd1);

    run_one("rne_tie_even", 1'b1, 1'b0, 2'b00, {1'b1, 52'h0, 1'b1, 1'b0}, 13'd5,
            53'h10_0000_0000_0000, 13'd5, 1'b1, 1'b0);
    run_one("rne_carry", 1'b1, 1'b0, 2'b00, {1'b1, {52{1'b1}}, 1'b1, 1'b0}, 13'd5,
            53'h10_0000_0000_0000, 13'd6, 1'b1, 1'b1);
    run_one("sgl_rpi_pos", 1'b0, 1'b0, 2'b10, {24'hFFFFFE, 1'b0, 1'b1, 29'd0}, 13'd20,
            {24'hFFFFFF, 29'd0}, 13'd20, 1'b1, 1'b0);
    run_one("sgl_rpi_neg", 1'b0, 1'b1, 2'b10, {24'hFFFFFE, 1'b0, 1'b1, 29'd0}, 13'd20,
            {24'hFFFFFE, 29'd0}, 13'd20, 1'b1, 1'b0);
    run_one("rz_trunc", 1'b1, 1'b0, 2'b01, {1'b1, 52'h123456789ABCD, 1'b1, 1'b1}, 13'd9,
            {1'b1, 52'h123456789ABCD}, 13'd9, 1'b1, 1'b0);
    run_one("rne_up", 1'b1, 1'b0, 2'b00, {1'b1, 52'h123456789ABCC, 1'b1, 1'b1}, 13'd9,
            {1'b1, 52'h123456789ABCD}, 13'd9, 1'b1, 1'b0);
    run_one("rne_tie_odd", 1'b1, 1'b0, 2'b00, {1'b1, 52'h123456789ABCD, 1'b1, 1'b0}, 13'd9,
            {1'b1, 52'h123456789ABCE}, 13'd9, 1'b1, 1'b0);
    run_one("rpi_exact", 1'b1, 1'b0, 2'b10, {1'b1, 52'h123456789ABCD, 1'b0, 1'b0}, 13'd9,
            {1'b1, 52'h123456789ABCD}, 13'd9, 1'b0, 1'b0);
    run_one("rni_neg", 1'b1, 1'b1, 2'b11, {1'b1, 52'h123456789ABCD, 1'b0, 1'b1}, 13'd9,
            {1'b1, 52'h123456789ABCE}, 13'd9, 1'b1, 1'b0);
    run_one("rni_pos", 1'b1, 1'b0, 2'b11, {1'b1, 52'h123456789ABCD, 1'b0, 1'b1}, 13'd9,
            {1'b1, 52'h123456789ABCD}, 13'd9, 1'b1, 1'b0);
    run_one("sgl_junk", 1'b0, 1'b0, 2'b00, {24'hABCDEF, 1'b0, 1'b0, {29{1'b1}}}, 13'd3,
            {24'hABCDEF, 29'd0}, 13'd3, 1'b0, 1'b0);
    run_one("sgl_tie_even", 1'b0, 1'b0, 2'b00, {24'hC00000, 1'b1, 1'b0, 29'd0}, 13'd3,
            {24'hC00000, 29'd0}, 13'd3, 1'b1, 1'b0);
    run_one("sgl_carry", 1'b0, 1'b0, 2'b00, {24'hFFFFFF, 1'b1, 1'b0, 29'd0}, 13'd7,
            53'h10_0000_0000_0000, 13'd8, 1'b1, 1'b1);
    run_one("exp_wrap", 1'b1, 1'b0, 2'b00, {1'b1, {52{1'b1}}, 1'b1, 1'b0}, 13'h1FFF,
            53'h10_0000_0000_0000, 13'h0000, 1'b1, 1'b1);
    run_one("exp_mid", 1'b1, 1'b1, 2'b00, {1'b1, {52{1'b1}}, 1'b1, 1'b0}, 13'h0FFF,
            53'h10_0000_0000_0000, 13'h1000, 1'b1, 1'b1);

    stream(0);
    stream(1);

    // Fill both stages with the output stalled, then reset mid-flight.
    @(negedge clk);
    out_ready = 1'b0; in_valid = 1'b1; db = 1'b1; rm = 2'b01; s = 1'b0;
    f1 = {1'b1, 52'h1, 2'b00}; e_in = 13'd1;
    @(negedge clk);
    f1 = {1'b1, 52'h2, 2'b00}; e_in = 13'd2;
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    chk("fl_full_vld", 64'(out_valid), 64'd1);
    chk("fl_full_rdy", 64'(in_ready), 64'd0);
    rst = 1'b1;
    #1;
    chk("fl_rst_vld", 64'(out_valid), 64'd0);
    chk("fl_rst_f2", 64'(f2), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
    #1 chk("fl_rel_rdy", 64'(in_ready), 64'd1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1 chk("fl_no_stale", 64'(out_valid), 64'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
